// File: rtl/wb_pkg.sv
// Shared constants and arithmetic helpers for the white-balance gain stage.
package wb_pkg;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    function automatic int unity_gain(input int fw);
        return 1 << fw;
    endfunction

    // Round-to-nearest (half up) of a fixed-point product, then clamp to dw bits.
    function automatic logic [63:0] sat_round(input logic [63:0] prod, input int fw, input int dw);
        logic [63:0] rnd;
        logic [63:0] max_v;
        rnd   = (prod + (64'd1 << (fw - 1))) >> fw;
        max_v = (64'd1 << dw) - 64'd1;
        return (rnd > max_v) ? max_v : rnd;
    endfunction

endpackage

// File: rtl/wb_stats.sv
// Per-channel frame accumulators for AWB firmware; used only when WB_STATS_EN is defined.
module wb_stats
    import wb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 3,
    parameter int COLOR_W = 2,
    parameter int STAT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_accept,
    input  logic                     in_sof,
    input  logic [COLOR_W-1:0]       in_color,
    input  logic [DATA_W-1:0]        in_value,
    output logic [NUM_CH*STAT_W-1:0] stat_sum,
    output logic                     stat_valid
);

    logic [STAT_W-1:0]        acc_q [NUM_CH];
    logic [STAT_W-1:0]        acc_d [NUM_CH];
    logic [NUM_CH*STAT_W-1:0] stat_sum_q, stat_sum_d;
    logic                     stat_valid_q, stat_valid_d;
    logic                     seen_sof_q, seen_sof_d;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + (STAT_W + 1)'(b);
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

    always_comb begin
        acc_d        = acc_q;
        stat_sum_d   = stat_sum_q;
        stat_valid_d = 1'b0;
        seen_sof_d   = seen_sof_q;
        if (in_accept) begin
            if (in_sof) begin
                seen_sof_d = 1'b1;
                // The first sof after reset closes no real frame, so it is not reported.
                if (seen_sof_q) begin
                    stat_valid_d = 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        stat_sum_d[c*STAT_W +: STAT_W] = acc_q[c];
                    end
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_d[c] = '0;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_color == COLOR_W'(c)) begin
                    acc_d[c] = sat_add(in_sof ? '0 : acc_q[c], in_value);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
            stat_sum_q   <= '0;
            stat_valid_q <= 1'b0;
            seen_sof_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            stat_sum_q   <= stat_sum_d;
            stat_valid_q <= stat_valid_d;
            seen_sof_q   <= seen_sof_d;
        end
    end

    assign stat_sum   = stat_sum_q;
    assign stat_valid = stat_valid_q;

endmodule

// File: rtl/wb_gain_pipe.sv
// Two-stage white-balance gain pipe with frame-synchronous double-buffered gains.
// Define WB_STATS_EN to add per-channel frame statistics (stat_sum/stat_valid).
module wb_gain_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAIN_IW = 2,
    parameter int GAIN_FW = 6,
    parameter int NUM_CH  = 3,
    parameter int COLOR_W = 2
`ifdef WB_STATS_EN
    ,
    parameter int STAT_W  = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_sof,
    input  logic [COLOR_W-1:0]         s_color,
    input  logic [DATA_W-1:0]          s_value,
    input  logic                       gain_wr,
    input  logic [COLOR_W-1:0]         gain_sel,
    input  logic [GAIN_IW+GAIN_FW-1:0] gain_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_sof,
    output logic [COLOR_W-1:0]         m_color,
    output logic [DATA_W-1:0]          m_value
`ifdef WB_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0]   stat_sum,
    output logic                       stat_valid
`endif
);

    localparam int GW = GAIN_IW + GAIN_FW;
    localparam int PW = DATA_W + GW;
    localparam logic [GW-1:0] UNITY = GW'(unity_gain(GAIN_FW));

    // Handshake: a beat moves on valid&&ready; the whole pipe advances when the
    // output register is empty or being drained, so s_ready follows m_ready combinationally.
    logic en;
    logic accept;

    logic [GW-1:0] pending_q [NUM_CH];
    logic [GW-1:0] pending_d [NUM_CH];
    logic [GW-1:0] active_q  [NUM_CH];
    logic [GW-1:0] active_d  [NUM_CH];
    logic [GW-1:0] sel_gain;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_sof_q,   s1_sof_d;
    logic [COLOR_W-1:0] s1_color_q, s1_color_d;
    logic [DATA_W-1:0]  s1_value_q, s1_value_d;
    logic [GW-1:0]      s1_gain_q,  s1_gain_d;

    logic               m_valid_q, m_valid_d;
    logic               m_sof_q,   m_sof_d;
    logic [COLOR_W-1:0] m_color_q, m_color_d;
    logic [DATA_W-1:0]  m_value_q, m_value_d;
    logic [PW-1:0]      prod;

    assign en     = !m_valid_q || m_ready;
    assign accept = s_valid && en;

    always_comb begin
        pending_d = pending_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gain_wr && gain_sel == COLOR_W'(c)) begin
                pending_d[c] = gain_data;
            end
        end
        // Bank swap reads pending before any same-cycle write.
        active_d = active_q;
        if (accept && s_sof) begin
            active_d = pending_q;
        end
        sel_gain = UNITY;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s_color == COLOR_W'(c)) begin
                sel_gain = active_d[c];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sof_d   = s1_sof_q;
        s1_color_d = s1_color_q;
        s1_value_d = s1_value_q;
        s1_gain_d  = s1_gain_q;
        m_valid_d  = m_valid_q;
        m_sof_d    = m_sof_q;
        m_color_d  = m_color_q;
        m_value_d  = m_value_q;
        prod       = PW'(s1_value_q) * PW'(s1_gain_q);
        if (en) begin
            s1_valid_d = s_valid;
            s1_sof_d   = s_sof;
            s1_color_d = s_color;
            s1_value_d = s_value;
            s1_gain_d  = sel_gain;
            m_valid_d  = s1_valid_q;
            m_sof_d    = s1_sof_q;
            m_color_d  = s1_color_q;
            m_value_d  = DATA_W'(sat_round(64'(prod), GAIN_FW, DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pending_q[c] <= UNITY;
                active_q[c]  <= UNITY;
            end
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_color_q <= '0;
            s1_value_q <= '0;
            s1_gain_q  <= UNITY;
            m_valid_q  <= 1'b0;
            m_sof_q    <= 1'b0;
            m_color_q  <= '0;
            m_value_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            active_q   <= active_d;
            s1_valid_q <= s1_valid_d;
            s1_sof_q   <= s1_sof_d;
            s1_color_q <= s1_color_d;
            s1_value_q <= s1_value_d;
            s1_gain_q  <= s1_gain_d;
            m_valid_q  <= m_valid_d;
            m_sof_q    <= m_sof_d;
            m_color_q  <= m_color_d;
            m_value_q  <= m_value_d;
        end
    end

    assign s_ready = en;
    assign m_valid = m_valid_q;
    assign m_sof   = m_sof_q;
    assign m_color = m_color_q;
    assign m_value = m_value_q;

`ifdef WB_STATS_EN
    wb_stats #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .COLOR_W (COLOR_W),
        .STAT_W  (STAT_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .in_accept  (accept),
        .in_sof     (s_sof),
        .in_color   (s_color),
        .in_value   (s_value),
        .stat_sum   (stat_sum),
        .stat_valid (stat_valid)
    );
`endif

endmodule

// File: tb/tb_wb_gain_pipe.sv
// Self-checking bench for wb_gain_pipe: directed cases plus randomized traffic against a reference model.
module tb_wb_gain_pipe;

  localparam int W = 11;  // {sof, color[1:0], value[7:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_sof;
  logic [1:0] s_color;
  logic [7:0] s_value;
  logic       gain_wr;
  logic [1:0] gain_sel;
  logic [7:0] gain_data;
  logic       m_valid, m_ready, m_sof;
  logic [1:0] m_color;
  logic [7:0] m_value;
`ifdef WB_STATS_EN
  logic [95:0] stat_sum;
  logic        stat_valid;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] exp_q[$];

  wb_gain_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_color   (s_color),
    .s_value   (s_value),
    .gain_wr   (gain_wr),
    .gain_sel  (gain_sel),
    .gain_data (gain_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sof     (m_sof),
    .m_color   (m_color),
    .m_value   (m_value)
`ifdef WB_STATS_EN
    ,
    .stat_sum  (stat_sum),
    .stat_valid(stat_valid)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: act=%0d req=%0d", name, act, exp);
  endtask

  // reference model and per-cycle compare, sampled on the falling edge
  int         pend[3];
  int         act_g[3];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_val;
  logic [1:0] prev_col;
  logic       prev_sof;
  longint     macc[3];
  longint     snap[3];
  logic       mseen    = 1'b0;
  logic       stat_pend = 1'b0;

  initial begin
    for (int c = 0; c < 3; c++) begin
      pend[c]  = 64;
      act_g[c] = 64;
      macc[c]  = 0;
      snap[c]  = 0;
    end
  end

  always @(negedge clk) begin
    int g;
    int e;
    logic [W-1:0] item;
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
        pend[c]  = 64;
        act_g[c] = 64;
        macc[c]  = 0;
      end
      prev_stall = 1'b0;
      mseen      = 1'b0;
      stat_pend  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_value", m_value, prev_val);
        chk("hold_color", m_color, prev_col);
        chk("hold_sof", m_sof, prev_sof);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          item = exp_q.pop_front();
          chk("model_value", m_value, item[7:0]);
          chk("model_color", m_color, item[9:8]);
          chk("model_sof", m_sof, item[10]);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_val   = m_value;
      prev_col   = m_color;
      prev_sof   = m_sof;
`ifdef WB_STATS_EN
      chk("stat_valid", stat_valid, stat_pend);
      if (stat_pend) begin
        for (int c = 0; c < 3; c++) chk("stat_sum", stat_sum[c*32 +: 32], snap[c]);
      end
`endif
      stat_pend = 1'b0;
      if (s_valid && s_ready) begin
        if (s_sof) begin
          for (int c = 0; c < 3; c++) act_g[c] = pend[c];
          if (mseen) begin
            for (int c = 0; c < 3; c++) snap[c] = macc[c];
            stat_pend = 1'b1;
          end
          mseen = 1'b1;
          for (int c = 0; c < 3; c++) macc[c] = 0;
        end
        g = (s_color < 3) ? act_g[s_color] : 64;
        e = (int'(s_value) * g + 32) / 64;
        if (e > 255) e = 255;
        exp_q.push_back({s_sof, s_color, 8'(e)});
        if (s_color < 3) begin
          macc[s_color] = macc[s_color] + longint'(s_value);
          if (macc[s_color] > 64'hFFFF_FFFF) macc[s_color] = 64'hFFFF_FFFF;
        end
      end
      if (gain_wr && gain_sel < 3) pend[gain_sel] = int'(gain_data);
    end
  end

  // driver tasks (called at posedge+1, return at posedge+1)
  task automatic send(input logic sof, input logic [1:0] col, input logic [7:0] val);
    int   n = 0;
    logic done = 1'b0;
    s_valid = 1'b1;
    s_sof   = sof;
    s_color = col;
    s_value = val;
    while (!done) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic wr_gain(input logic [1:0] sel, input logic [7:0] data);
    gain_wr   = 1'b1;
    gain_sel  = sel;
    gain_data = data;
    @(posedge clk);
    #1;
    gain_wr = 1'b0;
  endtask

  task automatic expect_out(input string name, input int exp_v, input int exp_c, output int lat);
    logic found = 1'b0;
    lat = 0;
    while (!found && lat < 20) begin
      @(negedge clk);
      lat++;
      if (m_valid && m_ready) found = 1'b1;
    end
    chk({name, "_seen"}, found, 1);
    chk({name, "_value"}, m_value, exp_v);
    chk({name, "_color"}, m_color, exp_c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   lat;
    logic acc_last;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_color = '0; s_value = '0;
    gain_wr = 1'b0; gain_sel = '0; gain_data = '0; m_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_value", m_value, 0);
    chk("reset_m_color", m_color, 0);
    chk("reset_s_ready", s_ready, 1);
`ifdef WB_STATS_EN
    chk("reset_stat_sum", stat_sum, 0);
    chk("reset_stat_valid", stat_valid, 0);
`endif
    @(posedge clk);
    #1;

    // unity after reset, latency
    send(1'b0, 2'd0, 8'd100);
    expect_out("unity", 100, 0, lat);
    chk("latency", lat, 2);

    // gain takes effect at sof
    wr_gain(2'd0, 8'h60);
    send(1'b1, 2'd0, 8'd101);
    expect_out("gain_r", 152, 0, lat);
    send(1'b0, 2'd1, 8'd100);
    expect_out("gain_g_unity", 100, 1, lat);

    // deferred update then saturation
    wr_gain(2'd2, 8'hFF);
    send(1'b0, 2'd2, 8'd200);
    expect_out("deferred_b", 200, 2, lat);
    send(1'b1, 2'd2, 8'd200);
    expect_out("sat_b", 255, 2, lat);

    // same-cycle write and sof
    wr_gain(2'd0, 8'h80);
    gain_wr = 1'b1; gain_sel = 2'd0; gain_data = 8'h40;
    send(1'b1, 2'd0, 8'd50);
    gain_wr = 1'b0;
    expect_out("samecyc_old", 100, 0, lat);
    send(1'b1, 2'd0, 8'd50);
    expect_out("samecyc_new", 50, 0, lat);

    // backpressure mid-stream
    fork
      begin
        for (int i = 1; i <= 8; i++) send(1'b0, 2'd1, 8'(i));
      end
      begin
        idle(4);
        m_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_s_ready", s_ready, 0);
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    idle(6);
    chk("stream_drained", exp_q.size(), 0);

    send(1'b0, 2'd3, 8'd77);
    expect_out("passthrough", 77, 3, lat);

`ifdef WB_STATS_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(1'b1, 2'd0, 8'd10);
    send(1'b0, 2'd1, 8'd20);
    send(1'b0, 2'd0, 8'd30);
    send(1'b1, 2'd2, 8'd0);
    chk("stats_pulse", stat_valid, 1);
    chk("stats_r", stat_sum[31:0], 40);
    chk("stats_g", stat_sum[63:32], 20);
    chk("stats_b", stat_sum[95:64], 0);
    idle(1);
    chk("stats_pulse_end", stat_valid, 0);
`endif

    // reset mid-frame drops in-flight beats
    idle(4);
    send(1'b0, 2'd0, 8'd9);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_drop_valid", m_valid, 0);
`ifdef WB_STATS_EN
    chk("rst_stat_sum", stat_sum, 0);
`endif
    idle(1);
    chk("rst_drop_valid2", m_valid, 0);

    // randomized traffic
    acc_last = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!s_valid || acc_last) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_sof   = ($urandom_range(0, 15) == 0);
        s_color = 2'($urandom_range(0, 3));
        s_value = 8'($urandom_range(0, 255));
      end
      m_ready   = ($urandom_range(0, 3) != 0);
      gain_wr   = ($urandom_range(0, 5) == 0);
      gain_sel  = 2'($urandom_range(0, 3));
      gain_data = 8'($urandom_range(0, 255));
      rst       = (cyc == 300);
      @(negedge clk);
      acc_last = s_valid && s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; s_sof = 1'b0; gain_wr = 1'b0; rst = 1'b0; m_ready = 1'b1;
    idle(8);
    chk("random_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_gain_pipe.md
Name: wb_gain_pipe

Overview:
- Parametrised white-balance gain stage, the next generation of the ISP WB block. Sits between demosaic/colour-tagged pixel stream and gamma.
- Applies a per-channel fixed-point gain with round-to-nearest and saturation.
- Uses a valid/ready handshake with backpressure.
- Gains are double-buffered and take effect only at start of frame, so there is no mid-frame colour tearing.

Parameters:
- DATA_W, 8, pixel value width.
- GAIN_IW, 2, gain integer bits.
- GAIN_FW, 6, gain fraction bits (must be >=1); gain width GW = GAIN_IW+GAIN_FW.
- NUM_CH, 3, number of gained channels; colour codes 0..NUM_CH-1 (0=R, 1=G, 2=B by default).
- COLOR_W, 2, colour tag width (2^COLOR_W >= NUM_CH+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block accepts beat this cycle.
- s_sof  in  1  beat is first pixel of a frame.
- s_color  in  COLOR_W  colour tag.
- s_value  in  DATA_W  pixel value.
- gain_wr  in  1  write pending gain.
- gain_sel  in  COLOR_W  channel index for gain_wr.
- gain_data  in  GW  unsigned fixed-point gain, GAIN_IW.GAIN_FW.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_sof  out  1  sof forwarded with beat.
- m_color  out  COLOR_W  colour forwarded.
- m_value  out  DATA_W  gained, rounded, saturated value.

Behaviour:
- Reset (rst=1 at clk edge):
  - m_valid, m_sof, m_color and m_value go to 0.
  - Both pipeline stages are emptied.
  - All pending and active gains go to unity (1<<GAIN_FW).
  - s_ready=1 in the cycle after reset.
  - Reset mid-frame drops all in-flight beats. No output beat is produced for them.
- Handshake:
  - A beat transfers on s_valid&&s_ready (input) or m_valid&&m_ready (output).
  - Global advance en = !m_valid || m_ready. s_ready = en (combinational from m_ready).
  - When en=0, both stages hold and m_* outputs are stable.
  - m_valid, once asserted, stays high until accepted.
- Pipeline: two register stages, latency 2 cycles from accept to m_valid with no stall, throughput 1 beat/cycle. Bubbles propagate as invalid stages.
  - Stage 1 registers sof, colour and value, plus the gain selected from the active bank (unity if colour >= NUM_CH).
  - Stage 2 registers m_* outputs:
    - prod = value*gain, width DATA_W+GW.
    - rnd = (prod + (1<<(GAIN_FW-1))) >> GAIN_FW.
    - m_value = rnd > 2^DATA_W-1 ? 2^DATA_W-1 : rnd.
- Gain banks:
  - gain_wr=1 writes gain_data into pending[gain_sel]. A write with gain_sel >= NUM_CH is ignored.
  - On an accepted input beat with s_sof=1, active <= pending for all channels, and that same beat uses the new active gains.
  - Same-cycle gain_wr and accepted sof beat: active takes the pending value from before the write; the write lands in pending only.
  - Gain writes are accepted regardless of s_ready or stall.
- Colour >= NUM_CH: value passes through unmodified (unity gain, no saturation possible).

Optional Feature:
- Macro WB_STATS_EN. Adds per-channel frame statistics for AWB firmware.
- Extra parameter STAT_W (default 32).
- Extra ports:
  - stat_sum (out, NUM_CH*STAT_W): channel c at bits [c*STAT_W +: STAT_W].
  - stat_valid (out, 1).
- Accumulation:
  - Each accepted input beat with colour < NUM_CH adds the pre-gain s_value to acc[colour].
  - Accumulators saturate at 2^STAT_W-1.
- Frame boundary:
  - On an accepted sof beat, stat_sum <= acc totals of the previous frame and stat_valid pulses for 1 cycle.
  - acc then restarts with that sof beat's value.
  - No pulse is generated on the first sof after reset.
- Reset: acc, stat_sum and stat_valid go to 0.
- Without the macro: no stats ports or logic. Data path is identical either way.

Decomposition:
- Package wb_pkg holds:
  - colour code constants CH_R, CH_G, CH_B;
  - a unity-gain function of GAIN_FW;
  - a saturating-round function used by stage 2.
- One natural sub-module, wb_stats, holds the accumulators and latch, instantiated only under WB_STATS_EN.

Test Plan:
1. Unity gain after reset: rst, then R beat value 100 with m_ready=1 -> m_value=100 exactly 2 cycles after accept, m_color=0.
2. Gain via sof:
   - Setup: gain_wr R=0x60 (1.5), then sof R beat 101 -> m_value=152 (151.5 rounded).
   - Then a G beat 100 -> m_value=100 (G still unity).
3. Deferred update and saturation:
   - gain_wr B=0xFF mid-frame, B beat 200 -> 200 (old gain).
   - Next sof B beat 200 -> 255 (saturated).
4. Same-cycle write and sof: pending R=0x80, then gain_wr R=0x40 coincident with sof R beat 50 -> m_value=100; next frame's sof R 50 -> 50.
5. Backpressure:
   - Stream values 1..8, m_ready low for 3 cycles mid-stream -> s_ready low in those cycles, m_value held stable, all 8 beats emerge in order with no loss or duplication.
   - Colour 3 beat 77 -> 77 passthrough.
6. WB_STATS_EN:
   - Frame of R 10, G 20, R 30, then sof -> stat_sum R=40, G=20, B=0, stat_valid high one cycle.
   - rst mid-frame -> m_valid=0 next cycle and stats cleared.
